// File: rtl/spi_txn_sequencer.sv
// Command-to-byte sequencer for the AS6500 SPI control path: owns chip select and drives the
// byte-level SPI master one byte at a time. Optional watchdog enabled by SPI_SEQ_TIMEOUT_EN.
module spi_txn_sequencer #(
  parameter int unsigned CS_SETUP = 2,
  parameter int unsigned CS_HOLD  = 2,
  parameter int unsigned BYTE_GAP = 1,
  parameter int unsigned TIMEOUT  = 64
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_cmd_valid,
  output logic       o_cmd_ready,
  input  logic [7:0] i_cmd_opcode,
  input  logic [3:0] i_cmd_len,
  input  logic       i_cmd_rd,
  input  logic [7:0] i_wr_byte,
  output logic       o_wr_ack,
  output logic       o_rd_dv,
  output logic [7:0] o_rd_byte,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err,
  output logic       o_spi_ssn,
  output logic [7:0] o_TX_Byte,
  output logic       o_TX_DV,
  input  logic       i_TX_Ready,
  input  logic       i_RX_DV,
  input  logic [7:0] i_RX_Byte
);

  typedef enum logic [2:0] {StIdle, StSetup, StSend, StWaitRx, StGap, StHold} state_e;

  localparam int unsigned SetupCyc = (CS_SETUP == 0) ? 1 : CS_SETUP;
  localparam int unsigned HoldCyc  = (CS_HOLD == 0) ? 1 : CS_HOLD;
  localparam int unsigned GapCyc   = (BYTE_GAP == 0) ? 1 : BYTE_GAP;
  localparam logic [7:0]  SetupLast = 8'(SetupCyc - 1);
  localparam logic [7:0]  HoldLast  = 8'(HoldCyc - 1);
  localparam logic [7:0]  GapLast   = 8'(GapCyc - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [4:0] idx_q, idx_d, idx_inc;
  logic [7:0] op_q, op_d;
  logic [3:0] len_q, len_d;
  logic       rd_q, rd_d;
  logic       ssn_q, ssn_d;
  logic       cmd_ready_q, cmd_ready_d;
  logic       busy_q, busy_d;
  logic [7:0] tx_byte_q, tx_byte_d;
  logic       tx_dv_q, tx_dv_d;
  logic       rd_dv_q, rd_dv_d;
  logic [7:0] rd_byte_q, rd_byte_d;
  logic       done_q, done_d;
  logic       issue, wr_ack;

`ifdef SPI_SEQ_TIMEOUT_EN
  localparam logic [7:0] TimeoutLim = 8'((TIMEOUT == 0) ? 1 : TIMEOUT);
  logic [7:0] wd_q, wd_d;
  logic       abort_q, abort_d;
  logic       err_q, err_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 8'd1;
    idx_d     = idx_q;
    idx_inc   = idx_q + 5'd1;
    op_d      = op_q;
    len_d     = len_q;
    rd_d      = rd_q;
    ssn_d     = ssn_q;
    tx_byte_d = tx_byte_q;
    tx_dv_d   = 1'b0;
    rd_dv_d   = 1'b0;
    rd_byte_d = rd_byte_q;
    done_d    = 1'b0;
    issue     = 1'b0;
    wr_ack    = 1'b0;
`ifdef SPI_SEQ_TIMEOUT_EN
    wd_d      = wd_q + 8'd1;
    abort_d   = abort_q;
    err_d     = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (i_cmd_valid && cmd_ready_q) begin
          op_d    = i_cmd_opcode;
          len_d   = i_cmd_len;
          rd_d    = i_cmd_rd;
          idx_d   = 5'd0;
          ssn_d   = 1'b0;
          state_d = StSetup;
`ifdef SPI_SEQ_TIMEOUT_EN
          abort_d = 1'b0;
`endif
        end
      end
      // The last SETUP/GAP cycle issues directly so the registered TX_DV lands on schedule.
      StSetup: begin
        if (cnt_q == SetupLast) begin
          if (i_TX_Ready) issue = 1'b1;
          else            state_d = StSend;
        end
      end
      StSend: begin
        if (i_TX_Ready) issue = 1'b1;
      end
      StWaitRx: begin
        if (i_RX_DV) begin
          if (rd_q && (idx_q != 5'd0)) begin
            rd_dv_d   = 1'b1;
            rd_byte_d = i_RX_Byte;
          end
          idx_d   = idx_inc;
          state_d = (idx_inc == ({1'b0, len_q} + 5'd1)) ? StHold : StGap;
        end
      end
      StGap: begin
        if (cnt_q == GapLast) begin
          if (i_TX_Ready) issue = 1'b1;
          else            state_d = StSend;
        end
      end
      StHold: begin
        if (cnt_q == HoldLast) begin
          state_d = StIdle;
          ssn_d   = 1'b1;
`ifdef SPI_SEQ_TIMEOUT_EN
          done_d  = !abort_q;
          err_d   = abort_q;
`else
          done_d  = 1'b1;
`endif
        end
      end
      default: state_d = StIdle;
    endcase

    if (issue) begin
      state_d = StWaitRx;
      tx_dv_d = 1'b1;
      if (idx_q == 5'd0) begin
        tx_byte_d = op_q;
      end else if (rd_q) begin
        tx_byte_d = 8'h00;
      end else begin
        tx_byte_d = i_wr_byte;
        wr_ack    = 1'b1;
      end
    end

`ifdef SPI_SEQ_TIMEOUT_EN
    if (((state_q == StSend) || (state_q == StWaitRx)) && (state_d == state_q) &&
        (wd_q == TimeoutLim)) begin
      state_d = StHold;
      abort_d = 1'b1;
      tx_dv_d = 1'b0;
    end
`endif

    if (state_d != state_q) begin
      cnt_d = 8'd0;
`ifdef SPI_SEQ_TIMEOUT_EN
      wd_d  = 8'd0;
`endif
    end
    // Ready reappears only after a full cycle in IDLE, i.e. the cycle after o_done.
    cmd_ready_d = (state_q == StIdle) && (state_d == StIdle);
    busy_d      = (state_d != StIdle);
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q     <= StIdle;
      cnt_q       <= 8'd0;
      idx_q       <= 5'd0;
      op_q        <= 8'h00;
      len_q       <= 4'd0;
      rd_q        <= 1'b0;
      ssn_q       <= 1'b1;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      tx_byte_q   <= 8'h00;
      tx_dv_q     <= 1'b0;
      rd_dv_q     <= 1'b0;
      rd_byte_q   <= 8'h00;
      done_q      <= 1'b0;
`ifdef SPI_SEQ_TIMEOUT_EN
      wd_q        <= 8'd0;
      abort_q     <= 1'b0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      op_q        <= op_d;
      len_q       <= len_d;
      rd_q        <= rd_d;
      ssn_q       <= ssn_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      tx_byte_q   <= tx_byte_d;
      tx_dv_q     <= tx_dv_d;
      rd_dv_q     <= rd_dv_d;
      rd_byte_q   <= rd_byte_d;
      done_q      <= done_d;
`ifdef SPI_SEQ_TIMEOUT_EN
      wd_q        <= wd_d;
      abort_q     <= abort_d;
      err_q       <= err_d;
`endif
    end
  end

  assign o_cmd_ready = cmd_ready_q;
  assign o_wr_ack    = wr_ack;
  assign o_rd_dv     = rd_dv_q;
  assign o_rd_byte   = rd_byte_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_spi_ssn   = ssn_q;
  assign o_TX_Byte   = tx_byte_q;
  assign o_TX_DV     = tx_dv_q;
`ifdef SPI_SEQ_TIMEOUT_EN
  assign o_err       = err_q;
`else
  assign o_err       = 1'b0;
`endif

endmodule

// File: tb/tb_spi_txn_sequencer.sv
// Directed self-checking bench for spi_txn_sequencer with a simple byte-level SPI master model.
// The stuck-master scenario runs only when SPI_SEQ_TIMEOUT_EN is defined.
module tb_spi_txn_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_cmd_valid = 1'b0;
  logic       o_cmd_ready;
  logic [7:0] i_cmd_opcode = 8'h00;
  logic [3:0] i_cmd_len = 4'd0;
  logic       i_cmd_rd = 1'b0;
  logic [7:0] i_wr_byte;
  logic       o_wr_ack, o_rd_dv, o_busy, o_done, o_err, o_spi_ssn, o_TX_DV;
  logic [7:0] o_rd_byte, o_TX_Byte;
  logic       tx_ready, rx_dv;
  logic [7:0] rx_byte;

  always #5 clk = ~clk;

  spi_txn_sequencer #(
    .CS_SETUP(2), .CS_HOLD(2), .BYTE_GAP(1), .TIMEOUT(64)
  ) dut (
    .i_Clk       (clk),
    .i_Rst_L     (rst_n),
    .i_cmd_valid (i_cmd_valid),
    .o_cmd_ready (o_cmd_ready),
    .i_cmd_opcode(i_cmd_opcode),
    .i_cmd_len   (i_cmd_len),
    .i_cmd_rd    (i_cmd_rd),
    .i_wr_byte   (i_wr_byte),
    .o_wr_ack    (o_wr_ack),
    .o_rd_dv     (o_rd_dv),
    .o_rd_byte   (o_rd_byte),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_err       (o_err),
    .o_spi_ssn   (o_spi_ssn),
    .o_TX_Byte   (o_TX_Byte),
    .o_TX_DV     (o_TX_DV),
    .i_TX_Ready  (tx_ready),
    .i_RX_DV     (rx_dv),
    .i_RX_Byte   (rx_byte)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Master model: RX_DV 10 cycles after each TX_DV cycle; ignores TX_DV when stuck.
  logic [7:0] rx_mem [256];
  int         rx_ptr = 0;
  int         m_cnt;
  logic       stuck = 1'b0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt    <= 0;
      tx_ready <= 1'b1;
      rx_dv    <= 1'b0;
      rx_byte  <= 8'h00;
    end else begin
      rx_dv <= 1'b0;
      if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          rx_dv    <= 1'b1;
          rx_byte  <= rx_mem[rx_ptr % 256];
          rx_ptr   <= rx_ptr + 1;
          tx_ready <= 1'b1;
        end
      end else if (o_TX_DV && !stuck) begin
        m_cnt    <= 9;
        tx_ready <= 1'b0;
      end
    end
  end

  logic [7:0] wr_mem [256];
  int         wr_ptr = 0;
  assign i_wr_byte = wr_mem[wr_ptr % 256];
  always @(posedge clk) if (o_wr_ack) wr_ptr <= wr_ptr + 1;

  logic [7:0] tx_log [256];
  logic [7:0] rd_log [256];
  int tx_cyc [256];
  int rd_cyc [256];
  int tx_n = 0, wrack_n = 0, rd_n = 0, done_n = 0, err_n = 0, ssn_low_n = 0;
  int done_cyc = 0, err_cyc = 0;
  always @(negedge clk) begin
    if (o_TX_DV) begin
      tx_log[tx_n % 256] <= o_TX_Byte;
      tx_cyc[tx_n % 256] <= cyc;
      tx_n <= tx_n + 1;
    end
    if (o_rd_dv) begin
      rd_log[rd_n % 256] <= o_rd_byte;
      rd_cyc[rd_n % 256] <= cyc;
      rd_n <= rd_n + 1;
    end
    if (o_wr_ack) wrack_n <= wrack_n + 1;
    if (o_done) begin done_n <= done_n + 1; done_cyc <= cyc; end
    if (o_err) begin err_n <= err_n + 1; err_cyc <= cyc; end
    if (!o_spi_ssn) ssn_low_n <= ssn_low_n + 1;
  end

  int compared = 0;
  int mismatched = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input logic [7:0] op, input logic [3:0] len, input logic rd,
                       output int c0);
    i_cmd_valid  = 1'b1;
    i_cmd_opcode = op;
    i_cmd_len    = len;
    i_cmd_rd     = rd;
    c0 = cyc;
    check("accept_ready", {31'd0, o_cmd_ready}, 1);
    tick();
    i_cmd_valid = 1'b0;
  endtask

  task automatic wait_end(input string tag, input int budget);
    int base;
    int k;
    base = done_n + err_n;
    k = 0;
    while ((done_n + err_n == base) && (k < budget)) begin
      tick();
      k++;
    end
    check({tag, "_finish"}, done_n + err_n - base, 1);
    check({tag, "_ssn_high"}, {31'd0, o_spi_ssn}, 1);
    check({tag, "_ready_low"}, {31'd0, o_cmd_ready}, 0);
    check({tag, "_busy_low"}, {31'd0, o_busy}, 0);
    tick();
    check({tag, "_ready_back"}, {31'd0, o_cmd_ready}, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int c0, tb0, wa0, rd0, d0, s0, e0;
    for (int i = 0; i < 256; i++) begin
      rx_mem[i] = 8'hE0 ^ 8'(i);
      wr_mem[i] = 8'h00;
    end

    // Reset state
    tick();
    tick();
    check("rst_ssn", {31'd0, o_spi_ssn}, 1);
    check("rst_ready", {31'd0, o_cmd_ready}, 1);
    check("rst_txbyte", {24'd0, o_TX_Byte}, 32'h00);
    check("rst_rdbyte", {24'd0, o_rd_byte}, 32'h00);
    check("rst_outs", {26'd0, o_TX_DV, o_wr_ack, o_rd_dv, o_busy, o_done, o_err}, 0);
    rst_n = 1'b1;
    tick();
    tick();

    // Opcode-only
    tb0 = tx_n; wa0 = wrack_n; rd0 = rd_n; s0 = ssn_low_n;
    issue(8'h18, 4'd0, 1'b0, c0);
    wait_end("op_only", 100);
    check("op_only_txcount", tx_n - tb0, 1);
    check("op_only_byte", {24'd0, tx_log[tb0 % 256]}, 32'h18);
    check("op_only_tx_time", tx_cyc[tb0 % 256], c0 + 3);
    check("op_only_wrack", wrack_n - wa0, 0);
    check("op_only_rddv", rd_n - rd0, 0);
    check("op_only_done_time", done_cyc, c0 + 16);
    check("op_only_ssn_low", ssn_low_n - s0, 15);

    // Write, len 3, with a command offered while busy
    tb0 = tx_n; wa0 = wrack_n; rd0 = rd_n;
    wr_mem[wr_ptr % 256] = 8'hA1;
    wr_mem[(wr_ptr + 1) % 256] = 8'hB2;
    wr_mem[(wr_ptr + 2) % 256] = 8'hC3;
    issue(8'h80, 4'd3, 1'b0, c0);
    for (int i = 0; i < 5; i++) tick();
    i_cmd_valid = 1'b1; i_cmd_opcode = 8'hEE; i_cmd_len = 4'd0;
    check("wr_busy", {31'd0, o_busy}, 1);
    check("wr_holdoff", {31'd0, o_cmd_ready}, 0);
    check("wr_ssn_low", {31'd0, o_spi_ssn}, 0);
    for (int i = 0; i < 20; i++) tick();
    i_cmd_valid = 1'b0;
    wait_end("wr", 200);
    check("wr_txcount", tx_n - tb0, 4);
    check("wr_byte0", {24'd0, tx_log[tb0 % 256]}, 32'h80);
    check("wr_byte1", {24'd0, tx_log[(tb0 + 1) % 256]}, 32'hA1);
    check("wr_byte2", {24'd0, tx_log[(tb0 + 2) % 256]}, 32'hB2);
    check("wr_byte3", {24'd0, tx_log[(tb0 + 3) % 256]}, 32'hC3);
    for (int i = 0; i < 3; i++)
      check("wr_period", tx_cyc[(tb0 + i + 1) % 256] - tx_cyc[(tb0 + i) % 256], 12);
    check("wr_wrack", wrack_n - wa0, 3);
    check("wr_rddv", rd_n - rd0, 0);
    check("wr_done_time", done_cyc, c0 + 52);

    // Read, len 2
    tb0 = tx_n; wa0 = wrack_n; rd0 = rd_n;
    rx_mem[rx_ptr % 256] = 8'h55;
    rx_mem[(rx_ptr + 1) % 256] = 8'hAA;
    rx_mem[(rx_ptr + 2) % 256] = 8'h0F;
    issue(8'h40, 4'd2, 1'b1, c0);
    wait_end("rd", 200);
    check("rd_txcount", tx_n - tb0, 3);
    check("rd_byte0", {24'd0, tx_log[tb0 % 256]}, 32'h40);
    check("rd_byte1", {24'd0, tx_log[(tb0 + 1) % 256]}, 32'h00);
    check("rd_byte2", {24'd0, tx_log[(tb0 + 2) % 256]}, 32'h00);
    check("rd_count", rd_n - rd0, 2);
    check("rd_data0", {24'd0, rd_log[rd0 % 256]}, 32'hAA);
    check("rd_data1", {24'd0, rd_log[(rd0 + 1) % 256]}, 32'h0F);
    check("rd_dv_time", rd_cyc[rd0 % 256], c0 + 26);
    check("rd_wrack", wrack_n - wa0, 0);

    // Maximum length write
    tb0 = tx_n; wa0 = wrack_n; d0 = done_n;
    for (int i = 0; i < 15; i++) wr_mem[(wr_ptr + i) % 256] = 8'h10 + 8'(i);
    issue(8'h82, 4'd15, 1'b0, c0);
    wait_end("max", 400);
    check("max_txcount", tx_n - tb0, 16);
    check("max_last_byte", {24'd0, tx_log[(tb0 + 15) % 256]}, 32'h1E);
    check("max_wrack", wrack_n - wa0, 15);
    check("max_done_once", done_n - d0, 1);
    check("max_done_time", done_cyc, c0 + 196);

`ifdef SPI_SEQ_TIMEOUT_EN
    // Stuck master
    stuck = 1'b1;
    tb0 = tx_n; rd0 = rd_n; d0 = done_n; e0 = err_n;
    issue(8'h0B, 4'd2, 1'b1, c0);
    wait_end("stuck", 300);
    check("stuck_err", err_n - e0, 1);
    check("stuck_no_done", done_n - d0, 0);
    check("stuck_txcount", tx_n - tb0, 1);
    check("stuck_rddv", rd_n - rd0, 0);
    check("stuck_err_time", err_cyc, tx_cyc[tb0 % 256] + 67);
    stuck = 1'b0;
    d0 = done_n;
    issue(8'h18, 4'd0, 1'b0, c0);
    wait_end("after_stuck", 100);
    check("after_stuck_done", done_n - d0, 1);
`endif

    // Reset during byte 2 of a len-4 write
    tb0 = tx_n; d0 = done_n;
    for (int i = 0; i < 4; i++) wr_mem[(wr_ptr + i) % 256] = 8'hC0 + 8'(i);
    issue(8'h81, 4'd4, 1'b0, c0);
    for (int i = 0; (i < 200) && ((tx_n - tb0) < 2); i++) tick();
    check("rst_byte2_reached", tx_n - tb0, 2);
    rst_n = 1'b0;
    #1;
    check("rst_mid_ssn", {31'd0, o_spi_ssn}, 1);
    check("rst_mid_busy", {31'd0, o_busy}, 0);
    check("rst_mid_ready", {31'd0, o_cmd_ready}, 1);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) tick();
    check("rst_mid_no_done", done_n - d0, 0);
    tb0 = tx_n;
    wr_mem[wr_ptr % 256] = 8'h5A;
    issue(8'h9C, 4'd1, 1'b0, c0);
    wait_end("post_rst", 200);
    check("post_rst_txcount", tx_n - tb0, 2);
    check("post_rst_opcode", {24'd0, tx_log[tb0 % 256]}, 32'h9C);
    check("post_rst_data", {24'd0, tx_log[(tb0 + 1) % 256]}, 32'h5A);
    check("post_rst_tx_time", tx_cyc[tb0 % 256], c0 + 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/spi_txn_sequencer.md
# spi_txn_sequencer

Transaction sequencer for the AS6500 control path. It accepts one command (an opcode plus 0..15 data bytes) and drives the byte-level SPI master through its rising-edge-triggered TX_DV handshake, one byte at a time. It owns chip select, with programmable setup, hold and inter-byte gap. Write bytes are pulled from a byte stream; read bytes are returned as data-valid pulses.

## Interface
Parameters:
- CS_SETUP, default 2: cycles from o_spi_ssn low to first o_TX_DV; 0 is treated as 1.
- CS_HOLD, default 2: cycles from last i_RX_DV to o_spi_ssn high; 0 is treated as 1.
- BYTE_GAP, default 1: idle cycles between i_RX_DV and the next o_TX_DV; 0 is treated as 1.
- TIMEOUT, default 64: watchdog limit in cycles; used only with SPI_SEQ_TIMEOUT_EN.

Ports:
- i_Clk  in  1  system clock (same clock as the SPI master).
- i_Rst_L  in  1  asynchronous, active-low reset.
- i_cmd_valid  in  1  command request.
- o_cmd_ready  out  1  high only in IDLE.
- i_cmd_opcode  in  8  first byte shifted out.
- i_cmd_len  in  4  number of data bytes after the opcode (0..15).
- i_cmd_rd  in  1  1 = read (send 0x00, return RX bytes); 0 = write.
- i_wr_byte  in  8  write data, valid when o_wr_ack is high.
- o_wr_ack  out  1  one-cycle pulse: i_wr_byte consumed.
- o_rd_dv  out  1  one-cycle pulse: o_rd_byte valid.
- o_rd_byte  out  8  received data byte.
- o_busy  out  1  high whenever not in IDLE.
- o_done  out  1  one-cycle pulse on normal completion.
- o_err  out  1  one-cycle pulse on watchdog abort.
- o_spi_ssn  out  1  chip select, active low.
- o_TX_Byte  out  8  to SPI master.
- o_TX_DV  out  1  to SPI master.
- i_TX_Ready  in  1  from SPI master.
- i_RX_DV  in  1  from SPI master.
- i_RX_Byte  in  8  from SPI master.

## Operation
- Reset values:
  - o_spi_ssn = 1.
  - o_cmd_ready = 1.
  - o_TX_Byte = 0x00.
  - o_rd_byte = 0x00.
  - All other outputs 0.
- States: IDLE, SETUP, SEND, WAIT_RX, GAP, HOLD.
- IDLE:
  - Command accepted when i_cmd_valid && o_cmd_ready.
  - Latch opcode, len and rd.
  - Clear the byte index.
  - Go to SETUP.
- SETUP:
  - o_spi_ssn low.
  - Count CS_SETUP cycles, then go to SEND.
- SEND:
  - Wait for i_TX_Ready = 1.
  - Load o_TX_Byte:
    - index 0: opcode.
    - data phase, read: 0x00.
    - data phase, write: i_wr_byte, with o_wr_ack pulsed in the same cycle.
  - Assert o_TX_DV for exactly one cycle, then go to WAIT_RX.
- WAIT_RX:
  - o_TX_Byte held stable.
  - On i_RX_DV:
    - If read and index ≥ 1, pulse o_rd_dv with o_rd_byte = i_RX_Byte.
    - The RX byte during the opcode, and all RX bytes in write mode, are discarded.
    - Increment the index.
    - If index == len+1, go to HOLD; else go to GAP.
- GAP: count BYTE_GAP cycles, then go to SEND. o_TX_DV stays low throughout, which guarantees a fresh rising edge.
- HOLD: count CS_HOLD cycles, then o_spi_ssn high, pulse o_done, go to IDLE.
- i_cmd_len = 0 gives an opcode-only transaction: 1 byte, no o_wr_ack, no o_rd_dv.
- A command presented while busy is not accepted; it is held off by o_cmd_ready = 0.
- i_RX_DV outside WAIT_RX is ignored.
- Reset mid-transaction:
  - Immediate return to IDLE with reset values.
  - o_spi_ssn high asynchronously.
  - No o_done.
- Byte index is 5 bits. Timing counters are 8 bits; parameters must be ≤ 255.

## Timing
- Command accepted at cycle 0 → o_spi_ssn low at cycle 1 → first o_TX_DV at cycle 1+CS_SETUP, provided i_TX_Ready is high.
- Per byte: the master raises RX_DV 10 cycles after the TX_DV rising edge.
- Byte period: o_TX_DV to o_TX_DV = 10 + BYTE_GAP + 1 cycles.
- o_rd_dv is registered: it appears 1 cycle after the i_RX_DV sample.
- o_done occurs CS_HOLD+1 cycles after the final i_RX_DV, coincident with o_spi_ssn rising.
- o_cmd_ready returns high the cycle after o_done.
- Back-to-back commands have a minimum of 1 IDLE cycle between them, with ssn high.

## Configuration
- SPI_SEQ_TIMEOUT_EN defined:
  - A watchdog counts cycles spent in SEND (while i_TX_Ready is low) or in WAIT_RX.
  - When it reaches TIMEOUT:
    - o_TX_DV forced low.
    - Go directly to HOLD.
    - On exit, pulse o_err instead of o_done.
  - Remaining bytes are not sent; no further o_wr_ack or o_rd_dv occur.
  - The watchdog clears on every state change.
- SPI_SEQ_TIMEOUT_EN undefined:
  - No watchdog logic.
  - The sequencer waits indefinitely.
  - o_err is tied to 0.

## Test plan
- Opcode-only transaction: opcode 0x18, len 0 → exactly one o_TX_DV with byte 0x18, no o_wr_ack, ssn low for CS_SETUP + ~11 + CS_HOLD cycles, one o_done.
- Write transaction: opcode 0x80, len 3, write stream 0xA1, 0xB2, 0xC3 → TX sequence 0x80, A1, B2, C3; three o_wr_ack pulses; o_TX_DV gaps ≥ BYTE_GAP+1 cycles.
- Read transaction: opcode 0x40, len 2, SPI master model returning 0x55, 0xAA, 0x0F → TX sequence 0x40, 00, 00; o_rd_dv twice with bytes 0xAA, 0x0F; the opcode-phase byte 0x55 is not output.
- Maximum length: len 15 write → 16 bytes sent, byte index reaches 16, o_done once.
- Stuck master with SPI_SEQ_TIMEOUT_EN defined and TIMEOUT = 64: i_RX_DV never asserted → o_err at 64+CS_HOLD+1 cycles after o_TX_DV, ssn high, no o_done; the next command then completes normally.
- Reset mid-transaction: i_Rst_L pulled low during byte 2 of a len-4 write → ssn high immediately, o_busy = 0, no o_done; a new command after reset starts from the opcode.
